// File: rtl/uart_transmitter.sv
// Serial UART transmitter: start bit, DATA_WIDTH data bits LSB first, STOP_BITS stop bits.
// Idle-high registered line output, words accepted through a valid/ready handshake.
module uart_transmitter #(
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_pin,
    output logic                  tx_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      baud_cnt, baud_next;
    logic [IDX_W-1:0]      bit_idx, idx_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  pin_next;
    logic                  bit_end;

    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign tx_ready = (state == IDLE);
    assign tx_busy  = !tx_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_pin    <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= idx_next;
            shift_reg <= shift_next;
            tx_pin    <= pin_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_next = state;
        baud_next  = '0;
        idx_next   = bit_idx;
        shift_next = shift_reg;

        case (state)
            IDLE: begin
                idx_next = '0;
                if (tx_valid) begin
                    state_next = START;
                    shift_next = tx_data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    idx_next   = '0;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift_reg[DATA_WIDTH-1:1]};
                    if (bit_idx == DATA_LAST) begin
                        state_next = STOP;
                        idx_next   = '0;
                    end else begin
                        idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase

        // The line register follows the state being entered, so the start bit
        // appears directly after the accept edge.
        case (state_next)
            START:   pin_next = 1'b0;
            DATA:    pin_next = shift_next[0];
            default: pin_next = 1'b1;
        endcase
    end

endmodule
